// File: rtl/sum_entry_ctrl.sv
// Keypad sequencing controller for the decimal adder: collects two decimal operands,
// handshakes with the adder datapath and selects the display source.
module sum_entry_ctrl #(
    parameter int MAX_DIGITS = 3,
    parameter int OP_W       = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_valid,
    input  logic [3:0]      key_code,
    input  logic            done,
    output logic [OP_W-1:0] op_a,
    output logic [OP_W-1:0] op_b,
    output logic            start,
    output logic            busy,
    output logic [1:0]      disp_sel,
    output logic [1:0]      digit_cnt,
    output logic            overflow
);

    typedef enum logic [2:0] {
        S_ENTER_A = 3'd0,
        S_ENTER_B = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_SHOW    = 3'd4
    } state_t;

    localparam logic [1:0] MAX_CNT   = 2'(MAX_DIGITS);
    localparam logic [1:0] DISP_A    = 2'd0;
    localparam logic [1:0] DISP_B    = 2'd1;
    localparam logic [1:0] DISP_RES  = 2'd2;
    localparam logic [3:0] KEY_NEXT  = 4'hA;
    localparam logic [3:0] KEY_EQ    = 4'hB;
    localparam logic [3:0] KEY_CLR   = 4'hC;

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_a_q, op_a_d;
    logic [OP_W-1:0] op_b_q, op_b_d;
    logic            start_q, start_d;
    logic            busy_q, busy_d;
    logic [1:0]      disp_sel_q, disp_sel_d;
    logic [1:0]      digit_cnt_q, digit_cnt_d;
    logic            overflow_q, overflow_d;

    logic            key_digit;
    logic            key_next;
    logic            key_eq;
    logic            key_clr;
    logic            room;
    logic [OP_W+3:0] acc_a;
    logic [OP_W+3:0] acc_b;

    assign key_digit = key_valid && (key_code <= 4'd9);
    assign key_next  = key_valid && (key_code == KEY_NEXT);
    assign key_eq    = key_valid && (key_code == KEY_EQ);
    assign key_clr   = key_valid && (key_code == KEY_CLR);
    assign room      = digit_cnt_q < MAX_CNT;

    // Shift-in a decimal digit; the digit limit keeps the result inside OP_W.
    assign acc_a = {4'b0, op_a_q} * (OP_W+4)'(10) + {{OP_W{1'b0}}, key_code};
    assign acc_b = {4'b0, op_b_q} * (OP_W+4)'(10) + {{OP_W{1'b0}}, key_code};

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        disp_sel_d  = disp_sel_q;
        digit_cnt_d = digit_cnt_q;
        overflow_d  = overflow_q;

        case (state_q)
            S_ENTER_A: begin
                if (key_digit) begin
                    if (room) begin
                        op_a_d      = acc_a[OP_W-1:0];
                        digit_cnt_d = digit_cnt_q + 2'd1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (key_next) begin
                    state_d     = S_ENTER_B;
                    digit_cnt_d = 2'd0;
                    overflow_d  = 1'b0;
                    disp_sel_d  = DISP_B;
                end
            end
            S_ENTER_B: begin
                if (key_digit) begin
                    if (room) begin
                        op_b_d      = acc_b[OP_W-1:0];
                        digit_cnt_d = digit_cnt_q + 2'd1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (key_eq) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done) begin
                    state_d    = S_SHOW;
                    disp_sel_d = DISP_RES;
                end
            end
            S_SHOW: begin
                if (key_digit) begin
                    state_d     = S_ENTER_A;
                    op_a_d      = {{(OP_W-4){1'b0}}, key_code};
                    op_b_d      = '0;
                    digit_cnt_d = 2'd1;
                    disp_sel_d  = DISP_A;
                    overflow_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_ENTER_A;
            end
        endcase

        // Clear overrides everything, including a done seen in the same WAIT cycle.
        if (key_clr) begin
            state_d     = S_ENTER_A;
            op_a_d      = '0;
            op_b_d      = '0;
            disp_sel_d  = DISP_A;
            digit_cnt_d = 2'd0;
            overflow_d  = 1'b0;
        end

        start_d = (state_d == S_START);
        busy_d  = (state_d == S_START) || (state_d == S_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ENTER_A;
            op_a_q      <= '0;
            op_b_q      <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            disp_sel_q  <= DISP_A;
            digit_cnt_q <= 2'd0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            disp_sel_q  <= disp_sel_d;
            digit_cnt_q <= digit_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign start     = start_q;
    assign busy      = busy_q;
    assign disp_sel  = disp_sel_q;
    assign digit_cnt = digit_cnt_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/sum_entry_ctrl.md
Name: sum_entry_ctrl

Overview:
- Sequencing controller for the keypad-driven decimal adder path.
- Turns one-cycle keypad key events into two binary operands of up to MAX_DIGITS decimal digits each.
- Issues a start/done handshake to the adder datapath and selects which value the BCD display shows.
- Sits between the keypad decoder (key_valid/key_code) and the adder plus bin-to-BCD display chain.

Parameters:
- MAX_DIGITS, 3, maximum decimal digits accepted per operand.
- OP_W, 10, operand width in bits; must hold 10^MAX_DIGITS-1 (999 at the defaults).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- key_valid  input  1  one-cycle strobe: new key press.
- key_code  input  4  key value; 0-9 digit, 0xA next, 0xB equals, 0xC clear, 0xD/0xE/0xF ignored.
- done  input  1  adder result valid (pulse or level); sampled only in WAIT.
- op_a  output  OP_W  operand A, binary.
- op_b  output  OP_W  operand B, binary.
- start  output  1  one-cycle pulse requesting the adder to compute op_a+op_b.
- busy  output  1  high in START and WAIT.
- disp_sel  output  2  display source: 0 = op_a, 1 = op_b, 2 = result.
- digit_cnt  output  2  digits entered into the current operand.
- overflow  output  1  sticky; a digit was rejected because the operand was already full.

Behaviour:
- All state and outputs are registered. Key events are acted on in the cycle key_valid=1; outputs update on the next edge.
- Reset (rst=1 at a clock edge, any state, including mid-calculation):
  - state=ENTER_A; op_a=0; op_b=0.
  - digit_cnt=0; start=0; busy=0; disp_sel=0; overflow=0.
- States: ENTER_A, ENTER_B, START, WAIT, SHOW.
- ENTER_A:
  - Digit d with digit_cnt<MAX_DIGITS: op_a <= op_a*10+d; digit_cnt++.
  - Digit with digit_cnt==MAX_DIGITS: op_a unchanged; overflow<=1.
  - 0xA: -> ENTER_B; digit_cnt<=0; overflow<=0; disp_sel<=1.
  - 0xB: ignored.
- ENTER_B:
  - Digits accumulate into op_b with the same rules as ENTER_A.
  - 0xB: -> START; disp_sel stays 1.
  - 0xA: ignored.
- START:
  - start=1 for exactly this one cycle; busy=1.
  - Unconditionally -> WAIT next cycle.
  - op_a and op_b are frozen from entering START until leaving WAIT.
- WAIT:
  - busy=1; waits indefinitely.
  - done=1 -> SHOW; disp_sel<=2; busy<=0.
- SHOW:
  - op_a and op_b hold.
  - Digit d -> ENTER_A with op_a<=d, op_b<=0, digit_cnt<=1, disp_sel<=0, overflow<=0.
  - 0xA and 0xB: ignored.
- Clear (0xC) in any state: same effect as reset in the next cycle.
  - If it arrives in START, the start pulse still completes that cycle.
  - If it arrives in WAIT, it aborts; a later done is ignored because it is only sampled in WAIT.
- done asserted outside WAIT: ignored. done and clear in the same WAIT cycle: clear wins.
- key_valid=0: key_code ignored. Codes 0xD/0xE/0xF: no effect in any state.
- Arithmetic: op*10+d computed at OP_W+4 bits and truncated to OP_W. The MAX_DIGITS limit guarantees no overflow of OP_W.
- Digit keys in START/WAIT: ignored, and overflow is not set.

Test Plan:
- Basic sum: keys 1,2,3,A,4,5,6,B, then done two cycles after start.
  - op_a=123, op_b=456, digit_cnt=3 before A.
  - Single start pulse; busy high until done.
  - disp_sel=2 in SHOW.
- Overflow: keys 9,9,9,7 -> op_a=999, overflow=1. Then A -> overflow=0, disp_sel=1, digit_cnt=0.
- Short operands: keys 5,A,B -> op_a=5, op_b=0, start pulses once. Second B while in WAIT -> no second start.
- Abort: reach WAIT, key C, then done.
  - ENTER_A with op_a=0, op_b=0, disp_sel=0.
  - done ignored; no transition to SHOW.
- Restart from SHOW: after a result, key 7 -> ENTER_A, op_a=7, op_b=0, digit_cnt=1. Keys D/E/F and key_valid=0 with code 3 -> no change.
- Reset mid-entry: op_a=42 and in ENTER_B, assert rst one cycle -> all outputs at reset values next cycle; start never pulses.
